// File: rtl/bus_timer.sv
// bus_timer: fx68k bus slave with wait-stated DTACK and a prescaled 16-bit down-counter timer.
// Optional `BUS_TIMER_WDOG_EN adds CTRL.WDOG and a 16-cycle active-low wdog_rst_n_o pulse on expiry.

module bus_timer #(
    parameter int WAIT_STATES = 1,
    parameter int PRESCALE    = 25
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_i,
    input  logic        as_n_i,
    input  logic        uds_n_i,
    input  logic        lds_n_i,
    input  logic        rw_i,
    input  logic [1:0]  addr_i,
    input  logic [15:0] din_i,
    output logic [15:0] dout_o,
    output logic        dtack_n_o,
    output logic        irq_n_o
`ifdef BUS_TIMER_WDOG_EN
    ,
    output logic        wdog_rst_n_o
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [3:0]    ws_q, ws_d;
    logic          dtack_n_q, irq_n_q;
    logic [15:0]   dout_q, dout_d;
    logic          en_q, en_d, rl_q, rl_d, ie_q, ie_d, exp_q, exp_d;
    logic [15:0]   reload_q, reload_d, count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          access, wr, rd, tick, expire;
    logic [15:0]   rdata;
`ifdef BUS_TIMER_WDOG_EN
    logic          wdog_q, wdog_d;
    logic [4:0]    wd_cnt_q, wd_cnt_d;
`endif

    // Bus handshake; the register access happens on the first clock spent in ACK,
    // which is the same edge that drives DTACK low.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        case (state_q)
            S_IDLE: if (cs_i && !as_n_i) begin
                ws_d    = '0;
                state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (as_n_i)                              state_d = S_IDLE;
                else if (ws_q == 4'(WAIT_STATES - 1))    state_d = S_ACK;
                else                                     ws_d    = ws_q + 4'd1;
            end
            S_ACK:   if (as_n_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign access = (state_q == S_ACK) && dtack_n_q;
    assign wr     = access && !rw_i;
    assign rd     = access && rw_i;

    always_comb begin
        rdata = '0;
        case (addr_i)
            2'd0: begin
                rdata[0] = en_q;
                rdata[1] = rl_q;
                rdata[2] = ie_q;
`ifdef BUS_TIMER_WDOG_EN
                rdata[3] = wdog_q;
`endif
            end
            2'd1:    rdata[0] = exp_q;
            2'd2:    rdata    = reload_q;
            default: rdata    = count_q;
        endcase
    end

    assign tick   = en_q && (pre_q == PW'(PRESCALE - 1));
    assign expire = tick && (count_q == '0);

    // Timer update first, bus writes afterwards so a CTRL write overrides the
    // expiry's EN clear; the STATUS clear keeps EXP when expiry fires together.
    always_comb begin
        en_d     = en_q;
        rl_d     = rl_q;
        ie_d     = ie_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        pre_d    = pre_q;
        dout_d   = dout_q;
`ifdef BUS_TIMER_WDOG_EN
        wdog_d   = wdog_q;
        wd_cnt_d = (wd_cnt_q != '0) ? wd_cnt_q - 5'd1 : wd_cnt_q;
        if (expire && wdog_q) wd_cnt_d = 5'd16;
`endif
        if (en_q) pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
            if (!expire) begin
                count_d = count_q - 16'd1;
            end else begin
                exp_d = 1'b1;
                if (rl_q) count_d = reload_q;
                else      en_d    = 1'b0;
            end
        end
        if (rd) dout_d = rdata;
        if (wr) begin
            case (addr_i)
                2'd0: if (!lds_n_i) begin
                    en_d = din_i[0];
                    rl_d = din_i[1];
                    ie_d = din_i[2];
`ifdef BUS_TIMER_WDOG_EN
                    wdog_d = din_i[3];
`endif
                    if (din_i[0] && !en_q) begin
                        count_d = reload_q;
                        pre_d   = '0;
                    end
                end
                2'd1: if (!lds_n_i && din_i[0]) exp_d = expire;
                2'd2: begin
                    if (!uds_n_i) reload_d[15:8] = din_i[15:8];
                    if (!lds_n_i) reload_d[7:0]  = din_i[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            ws_q      <= '0;
            dtack_n_q <= 1'b1;
            irq_n_q   <= 1'b1;
            dout_q    <= '0;
            en_q      <= 1'b0;
            rl_q      <= 1'b0;
            ie_q      <= 1'b0;
            exp_q     <= 1'b0;
            reload_q  <= '0;
            count_q   <= '0;
            pre_q     <= '0;
`ifdef BUS_TIMER_WDOG_EN
            wdog_q    <= 1'b0;
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ws_q      <= ws_d;
            dtack_n_q <= (state_q != S_ACK);
            irq_n_q   <= !(exp_q && ie_q);
            dout_q    <= dout_d;
            en_q      <= en_d;
            rl_q      <= rl_d;
            ie_q      <= ie_d;
            exp_q     <= exp_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
`ifdef BUS_TIMER_WDOG_EN
            wdog_q    <= wdog_d;
            wd_cnt_q  <= wd_cnt_d;
`endif
        end
    end

    assign dout_o    = dout_q;
    assign dtack_n_o = dtack_n_q;
    assign irq_n_o   = irq_n_q;
`ifdef BUS_TIMER_WDOG_EN
    assign wdog_rst_n_o = (wd_cnt_q == '0);
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer (WAIT_STATES=1, PRESCALE=25).
// Build with +define+BUS_TIMER_WDOG_EN to also exercise the watchdog pulse.

module tb_bus_timer;

    logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b0, as_n = 1'b1;
    logic        uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        dtack_n, irq_n;
`ifdef BUS_TIMER_WDOG_EN
    logic        wdog_rst_n;
`endif

    int n_checks = 0, n_fail = 0, cyc = 0;

    // results of the last bus cycle
    logic [15:0] b_rd;
    int          b_lat, b_w;
    logic        b_irq1, b_dtm, b_dtm1;

    bus_timer #(.WAIT_STATES(1), .PRESCALE(25)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cs_i(cs), .as_n_i(as_n),
        .uds_n_i(uds_n), .lds_n_i(lds_n), .rw_i(rw), .addr_i(addr),
        .din_i(din), .dout_o(dout), .dtack_n_o(dtack_n), .irq_n_o(irq_n)
`ifdef BUS_TIMER_WDOG_EN
        , .wdog_rst_n_o(wdog_rst_n)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One full CPU cycle: b_lat = edges after the AS-sampling edge until DTACK low,
    // b_w = cycle number of that edge, b_dtm/b_irq1 at the edge AS is seen high, b_dtm1 one edge later.
    task automatic bus(input logic wr_en, input logic [1:0] a, input logic [15:0] d,
                       input logic u_n, input logic l_n);
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; rw = !wr_en; addr = a; din = d; uds_n = u_n; lds_n = l_n;
        @(posedge clk);
        b_lat = -1; b_w = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!dtack_n) begin b_lat = k; b_w = cyc; break; end
        end
        b_rd = dout;
        @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        @(posedge clk); #1; b_dtm = dtack_n; b_irq1 = irq_n;
        @(posedge clk); #1; b_dtm1 = dtack_n;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic rdr(input logic [1:0] a);
        bus(1'b0, a, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL rst_dtack: got %b want 1", dtack_n); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq: got %b want 1", irq_n); end
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", dout); end
`ifdef BUS_TIMER_WDOG_EN
        n_checks++; if (wdog_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_wdog: got %b want 1", wdog_rst_n); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_handshake;
        rdr(2'd0);
        n_checks++; if (b_lat !== 2) begin n_fail++; $display("FAIL hs_latency: got %0d want 2", b_lat); end
        n_checks++; if (b_rd !== 16'h0000) begin n_fail++; $display("FAIL hs_dout: got %h want 0000", b_rd); end
        n_checks++; if (b_dtm !== 1'b0) begin n_fail++; $display("FAIL hs_dtack_hold: got %b want 0", b_dtm); end
        n_checks++; if (b_dtm1 !== 1'b1) begin n_fail++; $display("FAIL hs_dtack_release: got %b want 1", b_dtm1); end
    endtask

    task automatic test_byte_lanes;
        logic [15:0] exp_ctrl;
        bus(1'b1, 2'd2, 16'hABCD, 1'b0, 1'b1);
        rdr(2'd2);
        n_checks++; if (b_rd !== 16'hAB00) begin n_fail++; $display("FAIL bl_upper: got %h want ab00", b_rd); end
        bus(1'b1, 2'd2, 16'h1234, 1'b1, 1'b0);
        rdr(2'd2);
        n_checks++; if (b_rd !== 16'hAB34) begin n_fail++; $display("FAIL bl_lower: got %h want ab34", b_rd); end
        bus(1'b1, 2'd2, 16'hFFFF, 1'b1, 1'b1);
        n_checks++; if (b_lat !== 2) begin n_fail++; $display("FAIL bl_nostrobe_ack: got %0d want 2", b_lat); end
        rdr(2'd2);
        n_checks++; if (b_rd !== 16'hAB34) begin n_fail++; $display("FAIL bl_nostrobe_data: got %h want ab34", b_rd); end
        wr(2'd3, 16'h7777);
        rdr(2'd3);
        n_checks++; if (b_rd !== 16'h0000) begin n_fail++; $display("FAIL bl_count_ro: got %h want 0000", b_rd); end
        wr(2'd0, 16'h00F8);
        rdr(2'd0);
`ifdef BUS_TIMER_WDOG_EN
        exp_ctrl = 16'h0008;
`else
        exp_ctrl = 16'h0000;
`endif
        n_checks++; if (b_rd !== exp_ctrl) begin n_fail++; $display("FAIL bl_ctrl_bits: got %h want %h", b_rd, exp_ctrl); end
        wr(2'd0, 16'h0000);
    endtask

    task automatic test_oneshot;
        int w;
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0005);
        w = b_w;
        wait_cyc(w + 100);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL os_irq_at_expiry: got %b want 1", irq_n); end
        wait_cyc(w + 101);
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL os_irq_after: got %b want 0", irq_n); end
        rdr(2'd1);
        n_checks++; if (b_rd !== 16'h0001) begin n_fail++; $display("FAIL os_status: got %h want 0001", b_rd); end
        rdr(2'd0);
        n_checks++; if (b_rd !== 16'h0004) begin n_fail++; $display("FAIL os_ctrl_en_clr: got %h want 0004", b_rd); end
        wait_cyc(cyc + 60);
        rdr(2'd3);
        n_checks++; if (b_rd !== 16'h0000) begin n_fail++; $display("FAIL os_count_frozen: got %h want 0000", b_rd); end
    endtask

    task automatic test_autoreload;
        int w;
        wr(2'd1, 16'h0001);
        n_checks++; if (b_irq1 !== 1'b1) begin n_fail++; $display("FAIL ar_clear_irq: got %b want 1", b_irq1); end
        wr(2'd2, 16'd1);
        wr(2'd0, 16'h0007);
        w = b_w;
        wait_cyc(w + 50);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL ar_irq_pre1: got %b want 1", irq_n); end
        wait_cyc(w + 51);
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL ar_irq_exp1: got %b want 0", irq_n); end
        wr(2'd1, 16'h0001);
        n_checks++; if (b_irq1 !== 1'b1) begin n_fail++; $display("FAIL ar_irq_clr: got %b want 1", b_irq1); end
        wait_cyc(w + 100);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL ar_irq_pre2: got %b want 1", irq_n); end
        wait_cyc(w + 101);
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL ar_irq_exp2: got %b want 0", irq_n); end
        rdr(2'd3);
        n_checks++; if (b_rd !== 16'h0001) begin n_fail++; $display("FAIL ar_count_reloaded: got %h want 0001", b_rd); end
        wr(2'd0, 16'h0004);
    endtask

    task automatic test_abort;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; rw = 1'b0; addr = 2'd2; din = 16'h5555; uds_n = 1'b0; lds_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (!dtack_n) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ab_no_dtack: got %b want 0", seen); end
        rdr(2'd2);
        n_checks++; if (b_rd !== 16'h0001) begin n_fail++; $display("FAIL ab_reg_kept: got %h want 0001", b_rd); end
    endtask

    task automatic test_reset_mid;
        logic got;
        got = 1'b0;
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL rm_irq_pre: got %b want 0", irq_n); end
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; rw = 1'b1; addr = 2'd2; uds_n = 1'b0; lds_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!dtack_n) begin got = 1'b1; break; end
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rm_dtack_seen: got %b want 1", got); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL rm_dtack_async: got %b want 1", dtack_n); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rm_irq_async: got %b want 1", irq_n); end
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL rm_dout_async: got %h want 0000", dout); end
        @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            rdr(2'(r));
            n_checks++; if (b_rd !== 16'h0000) begin n_fail++; $display("FAIL rm_reg%0d_zero: got %h want 0000", r, b_rd); end
        end
    endtask

`ifdef BUS_TIMER_WDOG_EN
    task automatic test_wdog;
        int w;
        wr(2'd0, 16'h000B);
        w = b_w;
        wait_cyc(w + 24);
        n_checks++; if (wdog_rst_n !== 1'b1) begin n_fail++; $display("FAIL wd_pre: got %b want 1", wdog_rst_n); end
        wait_cyc(w + 25);
        n_checks++; if (wdog_rst_n !== 1'b0) begin n_fail++; $display("FAIL wd_start: got %b want 0", wdog_rst_n); end
        wait_cyc(w + 40);
        n_checks++; if (wdog_rst_n !== 1'b0) begin n_fail++; $display("FAIL wd_last: got %b want 0", wdog_rst_n); end
        wait_cyc(w + 41);
        n_checks++; if (wdog_rst_n !== 1'b1) begin n_fail++; $display("FAIL wd_end: got %b want 1", wdog_rst_n); end
        wr(2'd0, 16'h0000);
    endtask
`endif

    initial begin
        test_reset;
        test_handshake;
        test_byte_lanes;
        test_oneshot;
        test_autoreload;
        test_abort;
        test_reset_mid;
`ifdef BUS_TIMER_WDOG_EN
        test_wdog;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/bus_timer.md
# bus_timer

Programmable 16-bit interval timer that responds as a slave on the fx68k CPU bus. It decodes an already-qualified chip select together with AS/UDS/LDS and generates its own DTACK with a configurable number of wait states. It provides a prescaled down-counter with one-shot and auto-reload modes, a sticky expiry flag and an active-low interrupt request. It sits beside the RAM/ACIA responders in the top level, with a dedicated `cs` from the address decoder.

## Interface
- `WAIT_STATES`, 1: clk cycles inserted between cycle acceptance and DTACK assertion (0..15).
- `PRESCALE`, 25: clk cycles per timer tick (≥1); 25 gives 1 µs at 25 MHz.
- `clk` in 1: system clock, 25 MHz, same domain as the CPU.
- `rst_n` in 1: active-low reset; asynchronous assert, all state cleared.
- `cs` in 1: chip select from the top-level address decoder.
- `as_n` in 1: CPU address strobe.
- `uds_n` in 1: upper data strobe; enables byte lane [15:8] on writes.
- `lds_n` in 1: lower data strobe; enables byte lane [7:0] on writes.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 2: register select, CPU address bits [2:1].
- `din` in 16: CPU write data.
- `dout` out 16: read data; reset 0.
- `dtack_n` out 1: data transfer acknowledge; reset 1.
- `irq_n` out 1: interrupt request, registered; reset 1.

## Operation
- Registers, selected by `addr`; all reset to 0:
  - 0 CTRL (RW): bit0 EN, bit1 RELOAD_MODE (1 = auto-reload), bit2 IE; other bits read 0.
  - 1 STATUS: bit0 EXP, sticky; writing 1 to bit0 clears it; other bits read 0.
  - 2 RELOAD (RW) [15:0].
  - 3 COUNT (RO): live counter; writes ignored.
- Bus FSM states: IDLE, WAIT, ACK.
  - IDLE → WAIT when `cs && !as_n` is sampled; go straight to ACK if WAIT_STATES = 0.
  - WAIT counts WAIT_STATES cycles, then → ACK.
  - In WAIT, if `as_n` is sampled high (aborted cycle): → IDLE with no write and no DTACK.
  - Entering ACK:
    - Write: update the register using the byte lanes enabled by the strobes. Both strobes high means no change, but the cycle still acknowledges.
    - Read: latch the full word into `dout`.
    - Either way, drive `dtack_n` low.
  - ACK holds `dtack_n` low until `as_n` is sampled high, then → IDLE with `dtack_n` high. `dout` holds its last value.
- Timer:
  - A CTRL write that takes EN 0→1 loads COUNT ← RELOAD and clears the prescaler.
  - While EN = 1, the prescaler counts 0..PRESCALE-1, issuing one tick per wrap.
  - On a tick with COUNT ≠ 0: COUNT decrements.
  - On a tick with COUNT = 0 (expiry):
    - EXP ← 1.
    - RELOAD_MODE = 1: COUNT ← RELOAD.
    - RELOAD_MODE = 0: EN ← 0.
  - Period is RELOAD+1 ticks.
  - A RELOAD write while running takes effect at the next reload.
  - EN = 0 freezes COUNT and the prescaler.
- `irq_n` is registered `!(EXP && IE)`.
- Simultaneous events:
  - EXP set by expiry and cleared by a write in the same cycle: set wins.
  - CTRL write clearing EN in the same cycle as expiry: the write wins, and EXP is still set.

## Timing
- `cs && !as_n` sampled at edge N: `dtack_n` falls at edge N+1+WAIT_STATES.
- Read data is valid on `dout` at the same edge that `dtack_n` falls.
- Write data becomes visible in the register at that same edge.
- `as_n` sampled high at edge M: `dtack_n` high at edge M+1.
- `as_n` is not synchronized; it is already in the `clk` domain.
- Expiry tick at edge T: EXP = 1 at T, `irq_n` low at T+1.
- Clearing EXP by a write at edge W: `irq_n` high at W+1.
- `rst_n` low mid-cycle: `dtack_n` and `irq_n` go high immediately. The FSM returns to IDLE, and a pending write is discarded.

## Configuration
- `BUS_TIMER_WDOG_EN` defined:
  - CTRL bit3 = WDOG, and output port `wdog_rst_n` (1 bit, reset 1) exists.
  - Expiry with WDOG = 1 drives `wdog_rst_n` low for exactly 16 clk cycles.
  - Any COUNT-reloading CTRL write (the EN 0→1 load) is the kick.
- Undefined: CTRL bit3 reads 0, writes are ignored, and the `wdog_rst_n` port is absent.

## Test plan
- Bus handshake, WAIT_STATES = 1: read CTRL after reset → `dtack_n` low 2 edges after AS is sampled, `dout` = 0x0000, and `dtack_n` high 1 edge after AS rises.
- Byte lanes: write RELOAD = 0xABCD with UDS only, then read RELOAD → 0xAB00; write 0x1234 with LDS only → read 0xAB34.
- One-shot: RELOAD = 3, CTRL = 0x0005 → EXP set after 4 ticks (100 clk), `irq_n` low one clk later, then EN reads 0 and COUNT stays at 0.
- Auto-reload: RELOAD = 1, CTRL = 0x0007 → expiry every 50 clk. Write STATUS = 0x0001 → `irq_n` high next clk and low again at the next expiry.
- Aborted cycle and reset: AS rises during WAIT → no DTACK and the register is unchanged. `rst_n` pulled low while `dtack_n` is low → `dtack_n` high immediately, and all registers read 0 afterwards.
- With `BUS_TIMER_WDOG_EN`: CTRL = 0x000B, RELOAD = 0 → `wdog_rst_n` low for exactly 16 clk starting at the expiry edge.
